mp64_mailbox: RTL and testbench
===============================

// Module: mp64_mailbox
// PURPOSE
//  Inter-core mailbox with inter-processor interrupts (IPIs) plus a bank of hardware spinlocks.
//  Sits on the shared MMIO bus as a single-cycle, byte-wide slave. The bus supplies the ID of
//  the requesting core. Each core has its own private data bytes, a per-sender IPI pending
//  mask, and an IRQ line. Spinlocks are test-and-set on read, and track their owner.
// PARAMETERS
//  NUM_CORES     4   number of cores; width of ipi_out and of each pending mask
//  CORE_ID_BITS  2   width of requester_id and of the lock owner field
//  NUM_LOCKS     16  number of spinlocks, 4-byte stride from 0x600
// PORTS
//  clk           in   1             single system clock; all state updates on rising edge
//  rst           in   1             asynchronous, active-high reset
//  req           in   1             bus request, one access per cycle
//  addr          in   12            MMIO offset
//  wdata         in   8             write data
//  wen           in   1             1 = write, 0 = read
//  rdata         out  8             read data, combinational from addr/requester/state
//  ack           out  1             = req (combinational; zero-wait-state)
//  requester_id  in   CORE_ID_BITS  ID of the accessing core
//  ipi_out       out  NUM_CORES     per-core IRQ; ipi_out[t] = |pending[t]
// BEHAVIOUR
//  Reset values
//   - All data bytes 0; all pending masks 0; all locks unlocked with owner 0.
//   - ipi_out = 0; rdata = 0 whenever req is low.
//  Access timing
//   - An access is valid when req is high.
//   - A read returns rdata in the same cycle, reflecting state before that cycle's edge.
//   - Side effects (writes, acquire) commit at the rising edge ending the req cycle.
//   - ipi_out is a function of registered state: it updates on the edge after a SEND or ACK write.
//  Mailbox region 0x500-0x5FF (r = requester_id)
//   - 0x500-0x507 DATA[0..7], RW: data bytes private to core r.
//     A read returns only r's own bytes; other cores' bytes are unaffected.
//   - 0x508 SEND, W: pending[wdata][r] <= 1.
//     If wdata >= NUM_CORES the write is ignored. A core may send to itself.
//   - 0x509 STATUS, R: {zero-pad, pending[r]}. bit s = IPI outstanding from sender s. No side effect.
//   - 0x50A ACK, W: pending[r][wdata] <= 0. Only the named sender's bit is cleared.
//     If wdata >= NUM_CORES the write is ignored.
//   - Repeated SENDs before an ACK coalesce into one pending bit.
//  Spinlock region 0x600 + 4*i + off (i = addr[7:2] < NUM_LOCKS)
//   - off 0 ACQUIRE, R (test-and-set):
//     - Lock free, or already owned by r: rdata = 0x00; the edge sets locked = 1, owner = r
//       (re-entrant; no nesting count).
//     - Lock held by another core: rdata = 0x01 and no state change.
//   - off 1 RELEASE, W:
//     - If locked and owner == r: locked <= 0.
//     - Otherwise ignored (non-owner release has no effect).
//   - off 2 LSTAT, R: {zero-pad, owner[CORE_ID_BITS-1:0], locked}. No side effect.
//   - Writes to ACQUIRE or LSTAT are ignored. A read of RELEASE returns 0x00.
//  Other accesses
//   - Unmapped offsets, including i >= NUM_LOCKS, read 0x00; writes to them are ignored.
//  Reset during an access
//   - Asserting reset mid-access discards the access, and all state returns to reset values.
//  Internal state names
//   - slock_locked[i] and slock_owner[i] are the required names; the bench probes them hierarchically.
// TESTING
//  1. Core 0 writes 0x42 to 0x500 and core 1 writes 0xFF to 0x500
//     -> core 0 reads 0x42 and core 1 reads 0xFF (private data).
//  2. Core 0 SENDs 0x01 -> ipi_out = 4'b0010 and core 1 STATUS = 0x01.
//     Core 1 ACKs 0x00 -> ipi_out = 0 and STATUS = 0x00.
//  3. Core 0 SENDs 1, 2 and 3 -> ipi_out = 4'b1110. Each core ACKs 0 -> ipi_out = 0.
//  4. Cores 0 and 2 SEND 3 -> core 3 STATUS = 0x05.
//     ACK 0 -> ipi_out = 4'b1000; then ACK 2 -> ipi_out = 0.
//  5. Core 0 reads 0x600 -> 0x00 (acquired). Core 1 reads 0x600 -> 0x01.
//     Core 0 writes 0x601 -> core 1 reads 0x600 -> 0x00 and core 0 then reads 0x01.
//     Core 2 reads 0x604 twice -> 0x00 both times (re-entrant).
//  6. Core 3 reads 0x614 -> 0x00 with owner[5] = 3.
//     Core 0 writes 0x615 -> lock still held. Core 3 writes 0x615 -> locked[5] = 0.
//     Locks 2 and 3 held by different cores stay independent.

Source files
------------

// File: rtl/mp64_mailbox_if.sv
// Byte-wide zero-wait-state MMIO bus between the core fabric and the mailbox.
// The bus also carries the requesting core's ID.
interface mp64_mailbox_if #(
    parameter int CORE_ID_BITS = 2
);
    logic                    req;
    logic [11:0]             addr;
    logic [7:0]              wdata;
    logic                    wen;
    logic [7:0]              rdata;
    logic                    ack;
    logic [CORE_ID_BITS-1:0] requester_id;

    modport master (
        output req, addr, wdata, wen, requester_id,
        input  rdata, ack
    );

    modport slave (
        input  req, addr, wdata, wen, requester_id,
        output rdata, ack
    );
endinterface

// File: rtl/mp64_mailbox.sv
// Inter-core mailbox: private per-core data bytes, per-sender IPI pending masks
// with IRQ lines, and a bank of owner-tracking test-and-set spinlocks.
module mp64_mailbox #(
    parameter int NUM_CORES    = 4,
    parameter int CORE_ID_BITS = 2,
    parameter int NUM_LOCKS    = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    mp64_mailbox_if.slave        bus,
    output logic [NUM_CORES-1:0] ipi_out
);
    localparam int         LOCK_BITS = (NUM_LOCKS > 1) ? $clog2(NUM_LOCKS) : 1;
    localparam logic [7:0] CORES_B   = 8'(NUM_CORES);
    localparam logic [6:0] LOCKS_B   = 7'(NUM_LOCKS);

    logic [7:0]              data_r    [NUM_CORES][8];
    logic [NUM_CORES-1:0]    pending_r [NUM_CORES];
    logic                    slock_locked [NUM_LOCKS];
    logic [CORE_ID_BITS-1:0] slock_owner  [NUM_LOCKS];

    logic [CORE_ID_BITS-1:0] rid_s;
    logic                    data_hit_s;
    logic                    send_hit_s;
    logic                    status_hit_s;
    logic                    ackw_hit_s;
    logic                    lock_hit_s;
    logic [LOCK_BITS-1:0]    lock_sel_s;
    logic [1:0]              lock_off_s;
    logic                    lock_busy_s;
    logic                    target_ok_s;
    logic [CORE_ID_BITS-1:0] target_s;
    logic                    acquire_s;
    logic                    release_s;
    logic [7:0]              rdata_s;

    // Address decode and lock arbitration for the current access
    always_comb begin
        rid_s        = bus.requester_id;
        data_hit_s   = bus.req && (bus.addr[11:8] == 4'h5) && (bus.addr[7:3] == 5'd0);
        send_hit_s   = bus.req && (bus.addr == 12'h508);
        status_hit_s = bus.req && (bus.addr == 12'h509);
        ackw_hit_s   = bus.req && (bus.addr == 12'h50A);
        lock_hit_s   = bus.req && (bus.addr[11:8] == 4'h6) && ({1'b0, bus.addr[7:2]} < LOCKS_B);
        lock_sel_s   = bus.addr[2 +: LOCK_BITS];
        lock_off_s   = bus.addr[1:0];
        // A lock only refuses the requester when someone else holds it
        lock_busy_s  = slock_locked[lock_sel_s] && (slock_owner[lock_sel_s] != rid_s);
        target_ok_s  = (bus.wdata < CORES_B);
        target_s     = bus.wdata[CORE_ID_BITS-1:0];
        acquire_s    = lock_hit_s && !bus.wen && (lock_off_s == 2'd0) && !lock_busy_s;
        release_s    = lock_hit_s && bus.wen && (lock_off_s == 2'd1)
                       && slock_locked[lock_sel_s] && (slock_owner[lock_sel_s] == rid_s);
    end

    // Read data mux, zero when idle or unmapped
    always_comb begin
        rdata_s = 8'h00;
        if (bus.req && !bus.wen) begin
            if (data_hit_s) begin
                rdata_s = data_r[rid_s][bus.addr[2:0]];
            end else if (status_hit_s) begin
                rdata_s = 8'(pending_r[rid_s]);
            end else if (lock_hit_s) begin
                case (lock_off_s)
                    2'd0:    rdata_s = {7'd0, lock_busy_s};
                    2'd2:    rdata_s = 8'({slock_owner[lock_sel_s], slock_locked[lock_sel_s]});
                    default: rdata_s = 8'h00;
                endcase
            end else begin
                rdata_s = 8'h00;
            end
        end else begin
            rdata_s = 8'h00;
        end
    end

    assign bus.rdata = rdata_s;
    assign bus.ack   = bus.req;

    // Per-core private data bytes
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int c = 0; c < NUM_CORES; c++) begin
                for (int b = 0; b < 8; b++) begin
                    data_r[c][b] <= 8'h00;
                end
            end
        end else if (data_hit_s && bus.wen) begin
            data_r[rid_s][bus.addr[2:0]] <= bus.wdata;
        end
    end

    // IPI pending masks: row = target core, bit = sender
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int c = 0; c < NUM_CORES; c++) begin
                pending_r[c] <= '0;
            end
        end else if (send_hit_s && bus.wen && target_ok_s) begin
            pending_r[target_s][rid_s] <= 1'b1;
        end else if (ackw_hit_s && bus.wen && target_ok_s) begin
            pending_r[rid_s][target_s] <= 1'b0;
        end
    end

    // Spinlock state: acquire on granted read, release by owner only
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_LOCKS; i++) begin
                slock_locked[i] <= 1'b0;
                slock_owner[i]  <= '0;
            end
        end else if (acquire_s) begin
            slock_locked[lock_sel_s] <= 1'b1;
            slock_owner[lock_sel_s]  <= rid_s;
        end else if (release_s) begin
            slock_locked[lock_sel_s] <= 1'b0;
        end
    end

    // IRQ per core is raised while any sender is outstanding
    always_comb begin
        ipi_out = '0;
        for (int t = 0; t < NUM_CORES; t++) begin
            ipi_out[t] = |pending_r[t];
        end
    end
endmodule

// File: tb/tb_mp64_mailbox.sv
// Scoreboard bench for mp64_mailbox: stimulus pushes model expectations,
// a negedge monitor pops and compares them against the DUT.
module tb_mp64_mailbox;
    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] ipi_out;

    mp64_mailbox_if #(.CORE_ID_BITS(2)) bus ();

    mp64_mailbox #(.NUM_CORES(4), .CORE_ID_BITS(2), .NUM_LOCKS(16)) dut (
        .clk     (clk),
        .rst     (rst),
        .bus     (bus),
        .ipi_out (ipi_out)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit         is_read;
        logic [7:0] rd;
        logic [3:0] ipi;
        int         lk;
        bit         lk_locked;
        logic [1:0] lk_owner;
    } exp_t;

    exp_t sb[$];
    int   compared   = 0;
    int   mismatched = 0;

    // Reference model state
    logic [7:0] m_data [4][8];
    logic [3:0] m_pend [4];   // m_pend[target][sender]
    bit         m_locked [16];
    logic [1:0] m_owner  [16];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic void model_reset();
        for (int c = 0; c < 4; c++) begin
            m_pend[c] = 4'd0;
            for (int b = 0; b < 8; b++) m_data[c][b] = 8'h00;
        end
        for (int i = 0; i < 16; i++) begin
            m_locked[i] = 1'b0;
            m_owner[i]  = 2'd0;
        end
    endfunction

    function automatic logic [3:0] model_ipi();
        logic [3:0] r;
        for (int t = 0; t < 4; t++) r[t] = (m_pend[t] != 4'd0);
        return r;
    endfunction

    function automatic int lock_index(input logic [11:0] a);
        if (a[11:8] == 4'h6 && int'(a[7:2]) < 16) return int'(a[7:2]);
        return -1;
    endfunction

    function automatic logic [7:0] model_read(input int core, input logic [11:0] a);
        int i;
        i = lock_index(a);
        if (a >= 12'h500 && a <= 12'h507) return m_data[core][a[2:0]];
        if (a == 12'h509) return {4'd0, m_pend[core]};
        if (i >= 0) begin
            if (a[1:0] == 2'd0) return (m_locked[i] && int'(m_owner[i]) != core) ? 8'h01 : 8'h00;
            if (a[1:0] == 2'd2) return {5'd0, m_owner[i], m_locked[i]};
        end
        return 8'h00;
    endfunction

    function automatic void model_update(input int core, input logic [11:0] a,
                                         input bit w, input logic [7:0] d);
        int i;
        i = lock_index(a);
        if (w) begin
            if (a >= 12'h500 && a <= 12'h507) m_data[core][a[2:0]] = d;
            if (a == 12'h508 && d < 8'd4) m_pend[int'(d)][core] = 1'b1;
            if (a == 12'h50A && d < 8'd4) m_pend[core][int'(d)] = 1'b0;
            if (i >= 0 && a[1:0] == 2'd1 && m_locked[i] && int'(m_owner[i]) == core)
                m_locked[i] = 1'b0;
        end else if (i >= 0 && a[1:0] == 2'd0) begin
            if (!m_locked[i] || int'(m_owner[i]) == core) begin
                m_locked[i] = 1'b1;
                m_owner[i]  = 2'(core);
            end
        end
    endfunction

    task automatic access(input int core, input logic [11:0] a, input bit w, input logic [7:0] d);
        exp_t e;
        @(posedge clk); #1;
        bus.req          = 1'b1;
        bus.requester_id = 2'(core);
        bus.addr         = a;
        bus.wen          = w;
        bus.wdata        = d;
        e.is_read   = !w;
        e.rd        = model_read(core, a);
        e.ipi       = model_ipi();
        e.lk        = (lock_index(a) >= 0) ? lock_index(a) : 0;
        e.lk_locked = m_locked[e.lk];
        e.lk_owner  = m_owner[e.lk];
        sb.push_back(e);
        model_update(core, a, w, d);
    endtask

    task automatic idle();
        @(posedge clk); #1;
        bus.req = 1'b0;
        bus.wen = 1'b0;
    endtask

    // Monitor: compare every access and every idle cycle against the model
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            check("rst_ipi", 32'(ipi_out), 32'd0);
        end else if (bus.req) begin
            if (sb.size() == 0) begin
                compared++;
                mismatched++;
                $display("FAIL sb_underflow: access seen with no expectation at %0t", $time);
            end else begin
                e = sb.pop_front();
                check("ack", 32'(bus.ack), 32'd1);
                if (e.is_read) check("rdata", 32'(bus.rdata), 32'(e.rd));
                check("ipi", 32'(ipi_out), 32'(e.ipi));
                check("lock_locked", 32'(dut.slock_locked[e.lk]), 32'(e.lk_locked));
                check("lock_owner", 32'(dut.slock_owner[e.lk]), 32'(e.lk_owner));
            end
        end else begin
            check("idle_rdata", 32'(bus.rdata), 32'd0);
            check("idle_ack", 32'(bus.ack), 32'd0);
            check("idle_ipi", 32'(ipi_out), 32'(model_ipi()));
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [11:0] a;
        logic [7:0]  d;
        int          core;
        bit          w;
        rst = 1'b1;
        bus.req = 1'b0; bus.wen = 1'b0; bus.addr = 12'h000;
        bus.wdata = 8'h00; bus.requester_id = 2'd0;
        model_reset();
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        idle();

        // Reset state
        for (int c = 0; c < 4; c++) begin
            access(c, 12'h500, 1'b0, 8'h00);
            access(c, 12'h509, 1'b0, 8'h00);
        end
        access(0, 12'h602, 1'b0, 8'h00);

        // Private data
        access(0, 12'h500, 1'b1, 8'h42);
        access(1, 12'h500, 1'b1, 8'hFF);
        access(0, 12'h500, 1'b0, 8'h00);
        access(1, 12'h500, 1'b0, 8'h00);

        // Single IPI and ack
        access(0, 12'h508, 1'b1, 8'h01);
        access(1, 12'h509, 1'b0, 8'h00);
        access(1, 12'h50A, 1'b1, 8'h00);
        access(1, 12'h509, 1'b0, 8'h00);
        idle();

        // Broadcast and individual acks
        for (int t = 1; t < 4; t++) access(0, 12'h508, 1'b1, 8'(t));
        idle();
        for (int t = 1; t < 4; t++) access(t, 12'h50A, 1'b1, 8'h00);
        idle();

        // Two senders to one target, coalescing, out-of-range target
        access(0, 12'h508, 1'b1, 8'h03);
        access(0, 12'h508, 1'b1, 8'h03);
        access(2, 12'h508, 1'b1, 8'h03);
        access(1, 12'h508, 1'b1, 8'h04);
        access(3, 12'h509, 1'b0, 8'h00);
        access(3, 12'h50A, 1'b1, 8'h00);
        access(3, 12'h50A, 1'b1, 8'h07);
        idle();
        access(3, 12'h50A, 1'b1, 8'h02);
        idle();

        // Spinlock contention, release, re-entrancy
        access(0, 12'h600, 1'b0, 8'h00);
        access(1, 12'h600, 1'b0, 8'h00);
        access(0, 12'h601, 1'b1, 8'h00);
        access(1, 12'h600, 1'b0, 8'h00);
        access(0, 12'h600, 1'b0, 8'h00);
        access(2, 12'h604, 1'b0, 8'h00);
        access(2, 12'h604, 1'b0, 8'h00);

        // Owner-only release and independent locks
        access(3, 12'h614, 1'b0, 8'h00);
        access(0, 12'h615, 1'b1, 8'h00);
        access(3, 12'h616, 1'b0, 8'h00);
        access(3, 12'h615, 1'b1, 8'h00);
        access(3, 12'h616, 1'b0, 8'h00);
        access(1, 12'h608, 1'b0, 8'h00);
        access(2, 12'h60C, 1'b0, 8'h00);
        access(2, 12'h609, 1'b1, 8'h00);
        access(1, 12'h60A, 1'b0, 8'h00);
        access(2, 12'h60E, 1'b0, 8'h00);
        access(1, 12'h600, 1'b1, 8'h00);
        access(2, 12'h601, 1'b0, 8'h00);

        // Unmapped offsets and out-of-range lock
        access(0, 12'h640, 1'b0, 8'h00);
        access(0, 12'h640, 1'b1, 8'h11);
        access(0, 12'h50B, 1'b0, 8'h00);
        access(0, 12'h000, 1'b0, 8'h00);
        access(0, 12'h7FF, 1'b1, 8'h55);

        // Randomized traffic
        for (int n = 0; n < 600; n++) begin
            core = int'($urandom_range(0, 3));
            w    = bit'($urandom_range(0, 1));
            d    = 8'($urandom);
            case ($urandom_range(0, 6))
                0: a = 12'h500 + 12'($urandom_range(0, 7));
                1: begin a = 12'h508; d = 8'($urandom_range(0, 5)); w = 1'b1; end
                2: a = 12'h509;
                3: begin a = 12'h50A; d = 8'($urandom_range(0, 5)); w = 1'b1; end
                4, 5: a = 12'h600 + 12'(4 * $urandom_range(0, 17) + $urandom_range(0, 3));
                default: begin
                    case ($urandom_range(0, 3))
                        0: a = 12'h50B;
                        1: a = 12'h5FF;
                        2: a = 12'h6C0;
                        default: a = 12'h000;
                    endcase
                end
            endcase
            if ($urandom_range(0, 7) == 0) idle();
            else access(core, a, w, d);
        end
        idle();

        // Build up state, then reset in the middle of an access
        access(1, 12'h503, 1'b1, 8'hA5);
        access(2, 12'h508, 1'b1, 8'h01);
        access(3, 12'h61C, 1'b0, 8'h00);
        @(posedge clk); #1;
        bus.req = 1'b1; bus.wen = 1'b1; bus.addr = 12'h508;
        bus.wdata = 8'h00; bus.requester_id = 2'd1;
        #1 rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        bus.req = 1'b0;
        bus.wen = 1'b0;
        model_reset();
        idle();
        access(1, 12'h503, 1'b0, 8'h00);
        access(1, 12'h509, 1'b0, 8'h00);
        access(0, 12'h509, 1'b0, 8'h00);
        access(0, 12'h61E, 1'b0, 8'h00);
        access(0, 12'h61C, 1'b0, 8'h00);
        idle();
        idle();

        check("sb_drained", 32'(sb.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
